// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//   Two-requester round-robin arbiter in front of a single-port memory.
//   Each transaction runs IDLE -> ACCESS -> DONE, one cycle per state.
//   The request is sampled at edge N and ack is high in cycle N+2.
//
// Ports
//   clock, reset           : single clock; asynchronous active-high reset
//   req0/1, we0/1          : request and write-enable per requester
//   addr0/1, wdata0/1      : word address and write data per requester
//   ack0/1                 : one-cycle completion pulse to the owner
//   rdata                  : memory word captured at the end of ACCESS
//   busy                   : high while the FSM is not in IDLE
//   mem_address            : memory port address
//   mem_input_data         : memory port write data
//   mem_write_enable       : memory port write enable
//   mem_output_data        : memory port read data
// ---------------------------------------------------------------------------
module memory_arbiter #(
  parameter int DW         = 32,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DW-1:0]         wdata0,
  input  logic [DW-1:0]         wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DW-1:0]         rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DW-1:0]         mem_input_data,
  output logic                  mem_write_enable,
  input  logic [DW-1:0]         mem_output_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic last_served;  // requester granted most recently
  logic owner;        // requester owning the in-flight transaction
  logic grant_valid;
  logic grant_sel;

  // Next state and arbitration decision.
  // NOTE: every variable written here is given a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    grant_valid = req0 | req1;
    // With both requesting, the one not served last wins; otherwise
    // whichever is requesting wins (req1 alone selects 1, else 0).
    grant_sel   = (req0 && req1) ? ~last_served : req1;

    unique case (state)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath registers. mem_write_enable is a flop that can only be set on
  // the IDLE->ACCESS edge and is cleared on every other edge, so it is high
  // for exactly the ACCESS cycle and cannot glitch. It also doubles as the
  // latched write flag, since ACCESS is a single cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_served      <= 1'b1;  // requester 0 wins the first contention
      owner            <= 1'b0;
      mem_address      <= '0;
      mem_input_data   <= '0;
      mem_write_enable <= 1'b0;
      rdata            <= '0;
      ack0             <= 1'b0;
      ack1             <= 1'b0;
    end else begin
      mem_write_enable <= 1'b0;
      ack0             <= 1'b0;
      ack1             <= 1'b0;

      if (state == IDLE && grant_valid) begin
        owner            <= grant_sel;
        last_served      <= grant_sel;
        mem_address      <= grant_sel ? addr1  : addr0;
        mem_input_data   <= grant_sel ? wdata1 : wdata0;
        mem_write_enable <= grant_sel ? we1    : we0;
      end

      // The memory answered on the falling edge inside ACCESS; capture it
      // and notify the owner whether or not it still holds req.
      if (state == ACCESS) begin
        rdata <= mem_output_data;
        ack0  <= ~owner;
        ack1  <= owner;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
//   Bench for memory_arbiter: a read-first memory answering on the falling
//   edge, a transaction-level reference model, directed scenarios with
//   literal expectations, and a randomized phase with occasional resets.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic          clock;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy, mem_write_enable;
  logic [DW-1:0] rdata, mem_input_data, mem_output_data;
  logic [AW-1:0] mem_address;

  int vectors;
  int miscompares;

  memory_arbiter #(.DW(DW), .ADDR_WIDTH(AW)) dut (
    .clock            (clock),
    .reset            (reset),
    .req0             (req0),
    .req1             (req1),
    .we0              (we0),
    .we1              (we1),
    .addr0            (addr0),
    .addr1            (addr1),
    .wdata0           (wdata0),
    .wdata1           (wdata1),
    .ack0             (ack0),
    .ack1             (ack1),
    .rdata            (rdata),
    .busy             (busy),
    .mem_address      (mem_address),
    .mem_input_data   (mem_input_data),
    .mem_write_enable (mem_write_enable),
    .mem_output_data  (mem_output_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [DW-1:0] init_val(input int a);
    return 32'hA5A5_0000 | (a & 32'h3FFF);
  endfunction

  // Memory device: read-first, acts on the falling edge.
  logic [DW-1:0] env_mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) env_mem[i] = init_val(i);
    mem_output_data = '0;
    forever begin
      @(negedge clock);
      mem_output_data = env_mem[mem_address];
      if (mem_write_enable) env_mem[mem_address] = mem_input_data;
    end
  end

  // Reference model: one transaction in flight, tracked as a stage count
  // (0 = nothing in flight, 1 = memory cycle, 2 = completion cycle).
  logic [DW-1:0] ref_mem [DEPTH];
  int            m_stage;
  int            m_last;
  int            m_owner;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  function automatic void model_reset();
    m_stage = 0;
    m_last  = 1;
    m_rdata = '0;
  endfunction

  task automatic model_step();
    int w;
    if (reset) begin
      model_reset();
      return;
    end
    case (m_stage)
      0: if (req0 || req1) begin
        if (req0 && req1) w = (m_last == 0) ? 1 : 0;
        else              w = req0 ? 0 : 1;
        m_owner = w;
        m_last  = w;
        m_we    = (w == 0) ? we0    : we1;
        m_addr  = (w == 0) ? addr0  : addr1;
        m_wdata = (w == 0) ? wdata0 : wdata1;
        m_stage = 1;
      end
      1: begin
        m_rdata = ref_mem[m_addr];
        if (m_we) ref_mem[m_addr] = m_wdata;
        m_stage = 2;
      end
      default: m_stage = 0;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("busy", {31'b0, busy}, {31'b0, m_stage != 0});
    check("ack0", {31'b0, ack0}, {31'b0, m_stage == 2 && m_owner == 0});
    check("ack1", {31'b0, ack1}, {31'b0, m_stage == 2 && m_owner == 1});
    check("mem_we", {31'b0, mem_write_enable}, {31'b0, m_stage == 1 && m_we});
    check("rdata", rdata, m_rdata);
    if (m_stage == 1) begin
      check("mem_address", {18'b0, mem_address}, {18'b0, m_addr});
      check("mem_input_data", mem_input_data, m_wdata);
    end
  endtask

  // One clock: model follows the rising edge; optional mid-cycle action
  // (1 = assert reset, 2 = change addr1); outputs compared on falling edge.
  task automatic tick(input int mid);
    @(posedge clock);
    model_step();
    if (mid != 0) begin
      #1;
      if (mid == 1) begin
        reset = 1'b1;
        model_reset();
      end else begin
        addr1 = 14'h3FFF;
      end
    end
    @(negedge clock);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick(0);
    tick(0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_acks", {30'b0, ack1, ack0}, 32'd0);
    check("rst_mem_we", {31'b0, mem_write_enable}, 32'd0);
    check("rst_mem_address", {18'b0, mem_address}, 32'd0);
    check("rst_mem_input_data", mem_input_data, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
  endtask

  // One request held for one cycle, observed for a bounded six cycles.
  task automatic single(input int p, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int mid_first,
                        output logic [DW-1:0] rd, output int lat,
                        output int we_cycles, output logic [AW-1:0] acc_addr);
    req0 = 1'b0;
    req1 = 1'b0;
    if (p == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end
    lat       = -1;
    we_cycles = 0;
    rd        = '0;
    acc_addr  = '0;
    for (int k = 1; k <= 6; k++) begin
      tick((k == 1) ? mid_first : 0);
      if (k == 1) begin
        req0     = 1'b0;
        req1     = 1'b0;
        acc_addr = mem_address;
      end
      if (mem_write_enable) we_cycles++;
      if (lat < 0 && ((p == 0) ? ack0 : ack1)) begin
        lat = k;
        rd  = rdata;
      end
    end
  endtask

  logic [DW-1:0] rd;
  logic [AW-1:0] acc_addr;
  int            lat, wec;
  int            ack_who[$];
  int            ack_at[$];
  logic [AW-1:0] pool [8];

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b1;
    req0   = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0  = '0;   addr1 = '0;  wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    model_reset();

    do_reset();

    // Single write, then read-back.
    single(0, 1'b1, 14'h0010, 32'hDEADBEEF, 0, rd, lat, wec, acc_addr);
    check("wr_latency", lat, 32'd2);
    check("wr_we_cycles", wec, 32'd1);
    check("wr_address", {18'b0, acc_addr}, 32'h0010);
    single(0, 1'b0, 14'h0010, 32'h0, 0, rd, lat, wec, acc_addr);
    check("rd_latency", lat, 32'd2);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_we_cycles", wec, 32'd0);

    // addr1 changes during ACCESS; the latched address must be used.
    single(1, 1'b0, 14'h0020, 32'h0, 2, rd, lat, wec, acc_addr);
    check("hold_address", {18'b0, acc_addr}, 32'h0020);
    check("hold_data", rd, 32'hA5A50020);

    // Boundary address via requester 1.
    single(1, 1'b1, 14'h3FFF, 32'h12345678, 0, rd, lat, wec, acc_addr);
    check("top_wr_latency", lat, 32'd2);
    single(1, 1'b0, 14'h3FFF, 32'h0, 0, rd, lat, wec, acc_addr);
    check("top_rd_latency", lat, 32'd2);
    check("top_rd_data", rd, 32'h12345678);

    // Reset during ACCESS of a write: no write, no ack.
    single(0, 1'b1, 14'h0005, 32'hCAFEF00D, 1, rd, lat, wec, acc_addr);
    check("abort_no_ack", lat, 32'hFFFF_FFFF);
    check("abort_no_write", wec, 32'd0);
    reset = 1'b0;
    single(0, 1'b0, 14'h0005, 32'h0, 0, rd, lat, wec, acc_addr);
    check("abort_readback", rd, 32'hA5A50005);

    // Contention straight after reset: order 0,1,0,1 every 3 cycles.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0001;
    req1 = 1'b1; we1 = 1'b0; addr1 = 14'h0002;
    for (int k = 1; k <= 12; k++) begin
      tick(0);
      if (ack0) begin ack_who.push_back(0); ack_at.push_back(k); end
      if (ack1) begin ack_who.push_back(1); ack_at.push_back(k); end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick(0); tick(0); tick(0);
    check("rr_count", ack_who.size(), 32'd4);
    if (ack_who.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("rr_owner", ack_who[i], i % 2);
        check("rr_cycle", ack_at[i], 2 + 3 * i);
      end
    end

    // Randomized traffic with occasional mid-cycle resets.
    pool[0] = 14'h0000; pool[1] = 14'h0001; pool[2] = 14'h0005; pool[3] = 14'h0010;
    pool[4] = 14'h0020; pool[5] = 14'h3FFE; pool[6] = 14'h3FFF; pool[7] = 14'h0123;
    for (int n = 0; n < 800; n++) begin
      reset  = 1'b0;
      req0   = ($urandom_range(0, 2) != 0);
      req1   = ($urandom_range(0, 2) != 0);
      we0    = $urandom_range(0, 1);
      we1    = $urandom_range(0, 1);
      addr0  = pool[$urandom_range(0, 7)];
      addr1  = pool[$urandom_range(0, 7)];
      wdata0 = $urandom;
      wdata1 = $urandom;
      tick(($urandom_range(0, 99) == 0) ? 1 : 0);
    end
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    tick(0); tick(0); tick(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
